// File: rtl/regfile_pkg.sv
// Shared types and sizing for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned RF_WIDTH = 32;
  localparam int unsigned RF_DEPTH = 32;
  localparam int unsigned RF_NRD   = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_state_e;

  // Index width for a file of the given depth; never narrower than one bit.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep sequencer: walks every entry once after reset or a clear
// request, then reports the file usable.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned AW    = calc_aw(RF_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          ready,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr
);

  rf_state_e     state_q;
  logic [AW-1:0] clr_idx_q;
  logic          ready_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_idx_q == AW'(DEPTH - 1)) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            ready_q   <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + AW'(1);
          end
        end
        IDLE: begin
          if (clear_req) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= CLEAR;
          clr_idx_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign sweep_we   = reset && (state_q == CLEAR);
  assign sweep_addr = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with busy scoreboard and clear sweep.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned  WIDTH    = RF_WIDTH,
  parameter int unsigned  DEPTH    = RF_DEPTH,
  parameter int unsigned  NRD      = RF_NRD,
  parameter int unsigned  ZERO_REG = 1,
  localparam int unsigned AW       = calc_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_req,
  output logic                 ready,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             sweep_we;
  logic [AW-1:0]    sweep_addr;
  logic             wr_ok;
  logic             iss_ok;
  logic [AW-1:0]    port_addr [NRD];
  logic [NRD-1:0]   port_ok;
  logic [NRD-1:0]   port_fwd;

  // In range and not the hardwired zero entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_fsm (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .ready      (ready),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // A clear request in the same cycle drops the write and the issue.
  assign wr_ok  = ready && !clear_req && wr_en    && addr_ok(wr_addr);
  assign iss_ok = ready && !clear_req && issue_en && addr_ok(issue_addr);

  // Single write port shared by sweep and writeback keeps the array RAM-mappable.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_addr] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Issue is applied after writeback so the newer producer keeps the entry busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= '0;
    end else if (ready && clear_req) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    assign port_addr[k] = rd_addr[k*AW +: AW];
    assign port_ok[k]   = ready && addr_ok(port_addr[k]);
`ifdef REGFILE_BYPASS_EN
    assign port_fwd[k]  = port_ok[k] && wr_ok && (wr_addr == port_addr[k]);
`else
    assign port_fwd[k]  = 1'b0;
`endif
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (port_fwd[k]) begin
        rd_data[k*WIDTH +: WIDTH] = wr_data;
        rd_busy[k]                = iss_ok && (issue_addr == port_addr[k]);
      end else if (port_ok[k]) begin
        rd_data[k*WIDTH +: WIDTH] = mem_q[port_addr[k]];
        rd_busy[k]                = busy_q[port_addr[k]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a 32-entry dual-port file with zero
// register and a 20-entry single-port file without one.
module tb_regfile_mp;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned D0 = 32;
  localparam int unsigned D1 = 20;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            clear_req;
  logic            wr_en      [2];
  logic [AW-1:0]   wr_addr    [2];
  logic [W-1:0]    wr_data    [2];
  logic            issue_en   [2];
  logic [AW-1:0]   issue_addr [2];
  logic [AW-1:0]   ra         [2][2];
  logic [2*AW-1:0] rd_addr0;
  logic [AW-1:0]   rd_addr1;
  logic            ready0, ready1;
  logic [2*W-1:0]  rd_data0;
  logic [1:0]      rd_busy0;
  logic [W-1:0]    rd_data1;
  logic [0:0]      rd_busy1;

  assign rd_addr0 = {ra[0][1], ra[0][0]};
  assign rd_addr1 = ra[1][0];

  regfile_mp #(.WIDTH(W), .DEPTH(D0), .NRD(2), .ZERO_REG(1)) u_dut0 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready0),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .issue_en(issue_en[0]), .issue_addr(issue_addr[0]),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_busy(rd_busy0)
  );

  regfile_mp #(.WIDTH(W), .DEPTH(D1), .NRD(1), .ZERO_REG(0)) u_dut1 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready1),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .issue_en(issue_en[1]), .issue_addr(issue_addr[1]),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1)
  );

  // Reference model: architectural contents, busy flags and remaining sweep cycles.
  logic [W-1:0] m_mem  [2][32];
  logic         m_busy [2][32];
  int           sweep_left [2];
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic int unsigned depth_of(input int d);
    return (d == 0) ? D0 : D1;
  endfunction

  function automatic int nrd_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic bit m_valid(input int d, input logic [AW-1:0] a);
    return (32'(a) < depth_of(d)) && !((d == 0) && (a == '0));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_rd(input int d, input logic [AW-1:0] a,
                        output logic [W-1:0] ed, output logic eb);
    ed = '0;
    eb = 1'b0;
    if (sweep_left[d] == 0 && m_valid(d, a)) begin
      if (BYP && wr_en[d] && !clear_req && m_valid(d, wr_addr[d]) && wr_addr[d] == a) begin
        ed = wr_data[d];
        eb = issue_en[d] && m_valid(d, issue_addr[d]) && issue_addr[d] == a;
      end else begin
        ed = m_mem[d][a];
        eb = m_busy[d][a];
      end
    end
  endtask

  task automatic check_all();
    logic [W-1:0] ed, od;
    logic         eb, ob;
    chk("ready0", 64'(ready0), 64'(sweep_left[0] == 0));
    chk("ready1", 64'(ready1), 64'(sweep_left[1] == 0));
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < nrd_of(d); k++) begin
        exp_rd(d, ra[d][k], ed, eb);
        od = (d == 0) ? rd_data0[k*W +: W] : rd_data1;
        ob = (d == 0) ? rd_busy0[k] : rd_busy1[0];
        chk($sformatf("d%0d_p%0d_data_r%0d", d, k, ra[d][k]), 64'(od), 64'(ed));
        chk($sformatf("d%0d_p%0d_busy_r%0d", d, k, ra[d][k]), 64'(ob), 64'(eb));
      end
    end
  endtask

  task automatic m_edge();
    for (int d = 0; d < 2; d++) begin
      if (!reset || (sweep_left[d] == 0 && clear_req)) begin
        sweep_left[d] = int'(depth_of(d));
        for (int i = 0; i < 32; i++) begin
          m_mem[d][i]  = '0;
          m_busy[d][i] = 1'b0;
        end
      end else if (sweep_left[d] > 0) begin
        sweep_left[d] = sweep_left[d] - 1;
      end else begin
        if (wr_en[d] && m_valid(d, wr_addr[d])) begin
          m_mem[d][wr_addr[d]]  = wr_data[d];
          m_busy[d][wr_addr[d]] = 1'b0;
        end
        if (issue_en[d] && m_valid(d, issue_addr[d])) begin
          m_busy[d][issue_addr[d]] = 1'b1;
        end
      end
    end
  endtask

  // Inputs change just after a rising edge; outputs are checked on the falling edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic set_idle();
    clear_req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_en[d]      = 1'b0;
      wr_addr[d]    = '0;
      wr_data[d]    = '0;
      issue_en[d]   = 1'b0;
      issue_addr[d] = '0;
      ra[d][0]      = '0;
      ra[d][1]      = '0;
    end
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (ready0 !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    set_idle();
    reset = 1'b0;
    sweep_left[0] = int'(D0);
    sweep_left[1] = int'(D1);
    @(posedge clk);
    m_edge();
    #1;
    repeat (3) step();

    // Reset release: full sweep before the file is usable.
    reset = 1'b1;
    wait_ready("reset_release_sweep", 32);
    ra[0][0] = 5'd31;
    ra[0][1] = 5'd1;
    step();

    // Write r5, read it on both ports.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
    ra[0][0] = 5'd5; ra[0][1] = 5'd5;
    step();
    wr_en[0] = 1'b0;
    #1;
    chk("r5_port0", 64'(rd_data0[W-1:0]), 64'h0000_0000_DEAD_BEEF);
    chk("r5_port1", 64'(rd_data0[2*W-1:W]), 64'h0000_0000_DEAD_BEEF);
    step();

    // Zero register ignores write and issue.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'h1234;
    issue_en[0] = 1'b1; issue_addr[0] = 5'd0;
    ra[0][0] = 5'd0; ra[0][1] = 5'd0;
    step();
    wr_en[0] = 1'b0; issue_en[0] = 1'b0;
    #1;
    chk("r0_data", 64'(rd_data0[W-1:0]), 64'h0);
    chk("r0_busy", 64'(rd_busy0[0]), 64'h0);
    step();

    // Scoreboard on r7.
    issue_en[0] = 1'b1; issue_addr[0] = 5'd7; ra[0][0] = 5'd7; ra[0][1] = 5'd7;
    step();
    issue_en[0] = 1'b0;
    #1;
    chk("r7_busy_after_issue", 64'(rd_busy0[0]), 64'h1);
    issue_en[0] = 1'b1; wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'h55;
    step();
    issue_en[0] = 1'b0; wr_en[0] = 1'b0;
    #1;
    chk("r7_busy_issue_and_write", 64'(rd_busy0[1]), 64'h1);
    chk("r7_data_issue_and_write", 64'(rd_data0[2*W-1:W]), 64'h55);
    wr_en[0] = 1'b1; wr_data[0] = 32'h66;
    step();
    wr_en[0] = 1'b0;
    #1;
    chk("r7_busy_after_write", 64'(rd_busy0[0]), 64'h0);
    step();

    // Same-cycle read of a register being written.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'hA5A5A5A5; ra[0][1] = 5'd9;
    #3;
    chk("r9_same_cycle", 64'(rd_data0[2*W-1:W]), BYP ? 64'hA5A5_A5A5 : 64'h0);
    step();
    wr_en[0] = 1'b0;
    step();

    // Fill r1..r31, then clear.
    for (int i = 1; i < 32; i++) begin
      wr_en[0] = 1'b1; wr_addr[0] = AW'(i); wr_data[0] = 32'(i);
      ra[0][0] = AW'(i); ra[0][1] = AW'(i - 1);
      step();
    end
    set_idle();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    wait_ready("clear_sweep", 32);
    for (int i = 0; i < 32; i += 2) begin
      ra[0][0] = AW'(i); ra[0][1] = AW'(i + 1);
      step();
    end
    ra[0][0] = 5'd31;
    #1;
    chk("r31_after_clear", 64'(rd_data0[W-1:0]), 64'h0);

    // Reset partway into a sweep restarts it.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    wait_ready("reset_mid_sweep", 32);

    // Small file: out-of-range addresses and an ordinary entry 0.
    wr_en[1] = 1'b1; wr_addr[1] = 5'd25; wr_data[1] = 32'hCAFE; ra[1][0] = 5'd25;
    issue_en[1] = 1'b1; issue_addr[1] = 5'd25;
    step();
    wr_en[1] = 1'b0; issue_en[1] = 1'b0;
    #1;
    chk("oor_data", 64'(rd_data1), 64'h0);
    chk("oor_busy", 64'(rd_busy1), 64'h0);
    wr_en[1] = 1'b1; wr_addr[1] = 5'd0; wr_data[1] = 32'h77; ra[1][0] = 5'd0;
    step();
    wr_en[1] = 1'b0;
    #1;
    chk("d1_r0_ordinary", 64'(rd_data1), 64'h77);
    step();

    // Randomized traffic on both files.
    for (int c = 0; c < 400; c++) begin
      clear_req = ($urandom_range(0, 63) == 0);
      for (int d = 0; d < 2; d++) begin
        wr_en[d]      = 1'($urandom_range(0, 1));
        wr_addr[d]    = AW'($urandom_range(0, 31));
        wr_data[d]    = $urandom;
        issue_en[d]   = ($urandom_range(0, 2) == 0);
        issue_addr[d] = ($urandom_range(0, 3) == 0) ? wr_addr[d] : AW'($urandom_range(0, 31));
        for (int k = 0; k < 2; k++) begin
          ra[d][k] = ($urandom_range(0, 3) == 0) ? wr_addr[d] : AW'($urandom_range(0, 31));
        end
      end
      step();
    end
    set_idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
